punc_control: RTL and testbench
===============================

# punc_control

Control unit for the PUnC LC3 processor. Sequences the PUnC datapath through fetch, decode and execute for each instruction. Drives every datapath strobe and select from its state, the instruction register and the n/z/p condition codes. Stops in a halt state on HALT (TRAP x25) or any unsupported opcode.

## Interface
Parameters:
- `OPCODE_W`, default 4: opcode field width, taken from IR[15:12].
- `CNT_W`, default 32: retired-instruction counter width (only with `PUNC_CTRL_PERF_EN`).

Ports:
- `clk`  in  1  clock. One clock domain, rising edge only.
- `rst`  in  1  reset, asynchronous, active-low.
- `ir`  in  16  instruction register from the datapath.
- `n`, `z`, `p`  in  1 each  condition codes.
- `mem_w_en`  out  1  memory write strobe.
- `mem_w_addr_sel`  out  1  0 = PC+sext9, 1 = R[IR[8:6]]+sext6.
- `mem_w_data_sel`  out  1  0 = register file port 0 data.
- `mem_r_addr_sel`  out  2  0 = PC, 1 = PC+sext9, 2 = R[IR[8:6]]+sext6.
- `rf_w_en`  out  1  register file write strobe.
- `rf_r0_addr_sel`  out  1  0 = IR[8:6], 1 = IR[11:9].
- `rf_r1_addr_sel`  out  1  0 = IR[2:0], 1 = IR[8:6].
- `rf_w_data_sel`  out  2  0 = ALU, 1 = memory data, 2 = PC, 3 = PC+sext9.
- `rf_w_addr_sel`  out  1  0 = IR[11:9], 1 = R7.
- `ir_ld`  out  1  load IR from memory data.
- `pc_ld`, `pc_clr`, `pc_inc`  out  1 each  PC controls.
- `pc_ld_data_sel`  out  2  0 = PC+sext9, 1 = register file port 0 data, 2 = PC+sext11.
- `alu_sel`  out  3  0 ADD, 1 ADD_I, 2 NOT, 3 AND, 4 AND_I, 5 PASS.
- `cond_ld`  out  1  load the condition codes.
- `cond_ld_data_sel`  out  1  0 = ALU output, 1 = register-file write data.
- `halted`  out  1  high while in HALT.
- `instr_count`  out  `CNT_W`  retired instructions (only with `PUNC_CTRL_PERF_EN`).

## Operation
- States: INIT → FETCH → DECODE → EXECUTE → FETCH …, plus HALT.
- Outputs are combinational from the state and `ir`. Any strobe not listed for a state is 0; a select not listed for a state is 0.
- INIT: `pc_clr`=1.
- FETCH: `mem_r_addr_sel`=0, `ir_ld`=1, `pc_inc`=1.
- DECODE: all strobes 0. Next state is HALT if the opcode is unsupported or IR = 0xF025; otherwise EXECUTE.
- HALT is absorbing; it is left only by reset.
- Unsupported opcodes are RTI (1000), reserved (1101), LDI (1010), STI (1011), and TRAP with a vector other than x25.
- EXECUTE, by opcode:
  - ADD/AND: `rf_w_en`=1, `cond_ld`=1, `cond_ld_data_sel`=0. If IR[5]=1, `alu_sel` = ADD_I/AND_I; otherwise `alu_sel` = ADD/AND and `rf_r1_addr_sel`=0.
  - NOT: `alu_sel`=2, `rf_w_en`=1, `cond_ld`=1, `cond_ld_data_sel`=0.
  - BR: `pc_ld_data_sel`=0. `pc_ld` = (IR[11]&n)|(IR[10]&z)|(IR[9]&p). BR with nzp=000 is a no-op.
  - JMP/RET: `rf_r0_addr_sel`=0, `pc_ld_data_sel`=1, `pc_ld`=1.
  - JSR (IR[11]=1) / JSRR: `rf_w_addr_sel`=1, `rf_w_data_sel`=2, `rf_w_en`=1, `pc_ld`=1.
    - `pc_ld_data_sel` is 2 for JSR and 1 for JSRR.
    - R7 receives the already-incremented PC on the same edge PC loads.
    - JSRR R7 uses the pre-write R7 value.
  - LD: `mem_r_addr_sel`=1, `rf_w_data_sel`=1.
  - LDR: `mem_r_addr_sel`=2, `rf_w_data_sel`=1.
  - LEA: `rf_w_data_sel`=3.
  - LD, LDR and LEA each also set `rf_w_en`=1, `cond_ld`=1, `cond_ld_data_sel`=1.
  - ST: `mem_w_addr_sel`=0, `rf_r0_addr_sel`=1, `mem_w_en`=1.
  - STR: `mem_w_addr_sel`=1, `rf_r1_addr_sel`=1, `rf_r0_addr_sel`=1, `mem_w_en`=1.

## Timing
- While `rst`=0: state is INIT, so `pc_clr`=1, all other outputs are 0, `halted`=0, and `instr_count`=0.
- INIT lasts exactly one cycle after `rst` deasserts.
- Every supported instruction takes 3 cycles: FETCH, DECODE, EXECUTE.
- First FETCH is cycle 1 after reset release.
- Memory reads are combinational, so IR is valid in the DECODE cycle.
- Asserting reset mid-EXECUTE forces INIT immediately. Any strobe on that edge is suppressed because INIT outputs apply.
- `halted` rises in the cycle after DECODE of a halting instruction.

## Configuration
- `PUNC_CTRL_PERF_EN` defined:
  - `instr_count` exists and increments by 1 on every EXECUTE cycle, wrapping modulo 2^`CNT_W`.
  - It holds in HALT and clears on reset.
- `PUNC_CTRL_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `punc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - all select encodings above, shared with the datapath defines;
  - the HALT word 0xF025.
- Sub-module `punc_ctrl_decode`: combinational mapping from {opcode, IR[11], IR[5], n, z, p} to the EXECUTE control word.
- `punc_control` holds the state register, next-state logic and counter.

## Test plan
- ADD R1,R2,#-1 with R2=0 → EXECUTE shows `alu_sel`=1, `rf_w_en`=1, `cond_ld`=1; afterwards R1=0xFFFF and n=1.
- BRz +4 with z=1 at PC 0x0010 → `pc_ld`=1 and `pc_ld_data_sel`=0 in EXECUTE. Repeat with z=0 → `pc_ld`=0.
- JSR +0x20 at address 0x0005 → R7=0x0006 and `pc_ld_data_sel`=2 in the same EXECUTE cycle.
- STR R3,R4,#2 → `mem_w_en`=1, `mem_w_addr_sel`=1, `rf_r0_addr_sel`=1, `rf_r1_addr_sel`=1 for exactly one cycle.
- IR=0xF025, then separately IR=0xD000 → HALT entered after DECODE; `halted`=1 persists 100 cycles; no strobes assert.
- Reset pulse during EXECUTE of LD → `rf_w_en` drops immediately, `pc_clr`=1, and FETCH restarts one cycle after release. With `PUNC_CTRL_PERF_EN`, `instr_count`=0.

Source files
------------

// File: rtl/punc_ctrl_pkg.sv
// Shared definitions for the PUnC control unit: FSM states, LC3 opcodes,
// datapath select encodings and the control-word layout.
package punc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [15:0] HALT_WORD = 16'hF025;

  localparam logic       MEM_W_ADDR_PC9  = 1'b0;
  localparam logic       MEM_W_ADDR_REG6 = 1'b1;
  localparam logic       MEM_W_DATA_R0   = 1'b0;
  localparam logic [1:0] MEM_R_ADDR_PC   = 2'd0;
  localparam logic [1:0] MEM_R_ADDR_PC9  = 2'd1;
  localparam logic [1:0] MEM_R_ADDR_REG6 = 2'd2;
  localparam logic       RF_R0_IR86      = 1'b0;
  localparam logic       RF_R0_IR119     = 1'b1;
  localparam logic       RF_R1_IR20      = 1'b0;
  localparam logic       RF_R1_IR86      = 1'b1;
  localparam logic [1:0] RF_WD_ALU       = 2'd0;
  localparam logic [1:0] RF_WD_MEM       = 2'd1;
  localparam logic [1:0] RF_WD_PC        = 2'd2;
  localparam logic [1:0] RF_WD_PC9       = 2'd3;
  localparam logic       RF_WA_IR119     = 1'b0;
  localparam logic       RF_WA_R7        = 1'b1;
  localparam logic [1:0] PC_LD_PC9       = 2'd0;
  localparam logic [1:0] PC_LD_R0        = 2'd1;
  localparam logic [1:0] PC_LD_PC11      = 2'd2;
  localparam logic [2:0] ALU_ADD         = 3'd0;
  localparam logic [2:0] ALU_ADD_I       = 3'd1;
  localparam logic [2:0] ALU_NOT         = 3'd2;
  localparam logic [2:0] ALU_AND         = 3'd3;
  localparam logic [2:0] ALU_AND_I       = 3'd4;
  localparam logic [2:0] ALU_PASS        = 3'd5;
  localparam logic       COND_ALU        = 1'b0;
  localparam logic       COND_RF_WD      = 1'b1;

  typedef struct packed {
    logic       mem_w_en;
    logic       mem_w_addr_sel;
    logic       mem_w_data_sel;
    logic [1:0] mem_r_addr_sel;
    logic       rf_w_en;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_ld_data_sel;
    logic [2:0] alu_sel;
    logic       cond_ld;
    logic       cond_ld_data_sel;
  } ctrl_t;

  // TRAP x25 is the only trap we honour and it halts; every other trap is unsupported.
  function automatic logic is_halt(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    return (ir == HALT_WORD) || (op == OP_TRAP) || (op == OP_RTI) ||
           (op == OP_RES) || (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/punc_ctrl_decode.sv
// EXECUTE-cycle control word for the PUnC datapath, derived from the
// opcode, IR[11:9], IR[5] and the n/z/p condition codes.
module punc_ctrl_decode
  import punc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] i_op,
  input  logic [2:0]          i_ir_nzp,
  input  logic                i_ir5,
  input  logic                i_n,
  input  logic                i_z,
  input  logic                i_p,
  output ctrl_t               o_ctrl
);

  logic w_br_take;
  assign w_br_take = (i_ir_nzp[2] & i_n) | (i_ir_nzp[1] & i_z) | (i_ir_nzp[0] & i_p);

  always_comb begin
    o_ctrl = '0;
    case (i_op)
      OP_ADD, OP_AND: begin
        o_ctrl.rf_w_en          = 1'b1;
        o_ctrl.cond_ld          = 1'b1;
        o_ctrl.cond_ld_data_sel = COND_ALU;
        if (i_ir5) begin
          o_ctrl.alu_sel = (i_op == OP_ADD) ? ALU_ADD_I : ALU_AND_I;
        end else begin
          o_ctrl.alu_sel        = (i_op == OP_ADD) ? ALU_ADD : ALU_AND;
          o_ctrl.rf_r1_addr_sel = RF_R1_IR20;
        end
      end
      OP_NOT: begin
        o_ctrl.alu_sel          = ALU_NOT;
        o_ctrl.rf_w_en          = 1'b1;
        o_ctrl.cond_ld          = 1'b1;
        o_ctrl.cond_ld_data_sel = COND_ALU;
      end
      OP_BR: begin
        o_ctrl.pc_ld_data_sel = PC_LD_PC9;
        o_ctrl.pc_ld          = w_br_take;
      end
      OP_JMP: begin
        o_ctrl.rf_r0_addr_sel = RF_R0_IR86;
        o_ctrl.pc_ld_data_sel = PC_LD_R0;
        o_ctrl.pc_ld          = 1'b1;
      end
      // R7 and PC load on the same edge, so JSRR R7 jumps through the old R7.
      OP_JSR: begin
        o_ctrl.rf_w_addr_sel  = RF_WA_R7;
        o_ctrl.rf_w_data_sel  = RF_WD_PC;
        o_ctrl.rf_w_en        = 1'b1;
        o_ctrl.pc_ld          = 1'b1;
        o_ctrl.rf_r0_addr_sel = RF_R0_IR86;
        o_ctrl.pc_ld_data_sel = i_ir_nzp[2] ? PC_LD_PC11 : PC_LD_R0;
      end
      OP_LD, OP_LDR, OP_LEA: begin
        o_ctrl.rf_w_en          = 1'b1;
        o_ctrl.cond_ld          = 1'b1;
        o_ctrl.cond_ld_data_sel = COND_RF_WD;
        if (i_op == OP_LEA) begin
          o_ctrl.rf_w_data_sel = RF_WD_PC9;
        end else begin
          o_ctrl.rf_w_data_sel  = RF_WD_MEM;
          o_ctrl.mem_r_addr_sel = (i_op == OP_LD) ? MEM_R_ADDR_PC9 : MEM_R_ADDR_REG6;
        end
      end
      OP_ST: begin
        o_ctrl.mem_w_addr_sel = MEM_W_ADDR_PC9;
        o_ctrl.mem_w_data_sel = MEM_W_DATA_R0;
        o_ctrl.rf_r0_addr_sel = RF_R0_IR119;
        o_ctrl.mem_w_en       = 1'b1;
      end
      OP_STR: begin
        o_ctrl.mem_w_addr_sel = MEM_W_ADDR_REG6;
        o_ctrl.mem_w_data_sel = MEM_W_DATA_R0;
        o_ctrl.rf_r1_addr_sel = RF_R1_IR86;
        o_ctrl.rf_r0_addr_sel = RF_R0_IR119;
        o_ctrl.mem_w_en       = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control unit: INIT -> FETCH -> DECODE -> EXECUTE loop plus HALT.
// Define PUNC_CTRL_PERF_EN to add the instr_count retired-instruction counter.
module punc_control
  import punc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
`ifdef PUNC_CTRL_PERF_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir,
  input  logic             n,
  input  logic             z,
  input  logic             p,
  output logic             mem_w_en,
  output logic             mem_w_addr_sel,
  output logic             mem_w_data_sel,
  output logic [1:0]       mem_r_addr_sel,
  output logic             rf_w_en,
  output logic             rf_r0_addr_sel,
  output logic             rf_r1_addr_sel,
  output logic [1:0]       rf_w_data_sel,
  output logic             rf_w_addr_sel,
  output logic             ir_ld,
  output logic             pc_ld,
  output logic             pc_clr,
  output logic             pc_inc,
  output logic [1:0]       pc_ld_data_sel,
  output logic [2:0]       alu_sel,
  output logic             cond_ld,
  output logic             cond_ld_data_sel,
  output logic             halted
`ifdef PUNC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  state_t r_state, w_next;
  ctrl_t  w_exec, w_ctrl;

  punc_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .i_op     (ir[15 -: OPCODE_W]),
    .i_ir_nzp (ir[11:9]),
    .i_ir5    (ir[5]),
    .i_n      (n),
    .i_z      (z),
    .i_p      (p),
    .o_ctrl   (w_exec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      S_INIT: begin
        w_ctrl.pc_clr = 1'b1;
        w_next        = S_FETCH;
      end
      S_FETCH: begin
        w_ctrl.mem_r_addr_sel = MEM_R_ADDR_PC;
        w_ctrl.ir_ld          = 1'b1;
        w_ctrl.pc_inc         = 1'b1;
        w_next                = S_DECODE;
      end
      S_DECODE:  w_next = is_halt(ir) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        w_ctrl = w_exec;
        w_next = S_FETCH;
      end
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_INIT;
    endcase
  end

  assign mem_w_en         = w_ctrl.mem_w_en;
  assign mem_w_addr_sel   = w_ctrl.mem_w_addr_sel;
  assign mem_w_data_sel   = w_ctrl.mem_w_data_sel;
  assign mem_r_addr_sel   = w_ctrl.mem_r_addr_sel;
  assign rf_w_en          = w_ctrl.rf_w_en;
  assign rf_r0_addr_sel   = w_ctrl.rf_r0_addr_sel;
  assign rf_r1_addr_sel   = w_ctrl.rf_r1_addr_sel;
  assign rf_w_data_sel    = w_ctrl.rf_w_data_sel;
  assign rf_w_addr_sel    = w_ctrl.rf_w_addr_sel;
  assign ir_ld            = w_ctrl.ir_ld;
  assign pc_ld            = w_ctrl.pc_ld;
  assign pc_clr           = w_ctrl.pc_clr;
  assign pc_inc           = w_ctrl.pc_inc;
  assign pc_ld_data_sel   = w_ctrl.pc_ld_data_sel;
  assign alu_sel          = w_ctrl.alu_sel;
  assign cond_ld          = w_ctrl.cond_ld;
  assign cond_ld_data_sel = w_ctrl.cond_ld_data_sel;
  assign halted           = (r_state == S_HALT);

`ifdef PUNC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_instr_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_instr_count <= '0;
    else if (r_state == S_EXECUTE)  r_instr_count <= r_instr_count + 1'b1;
  end

  assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_punc_control.sv
// Self-checking bench for punc_control: per-cycle control-word scoreboard
// driven from an instruction table plus halt and reset sequences.
module tb_punc_control;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] ir;
  logic n, z, p;
  logic mem_w_en, mem_w_addr_sel, mem_w_data_sel;
  logic [1:0] mem_r_addr_sel;
  logic rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel;
  logic [1:0] rf_w_data_sel;
  logic rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc;
  logic [1:0] pc_ld_data_sel;
  logic [2:0] alu_sel;
  logic cond_ld, cond_ld_data_sel, halted;
`ifdef PUNC_CTRL_PERF_EN
  logic [31:0] instr_count;
`endif

  always #5 clk = ~clk;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel),
    .mem_w_data_sel(mem_w_data_sel), .mem_r_addr_sel(mem_r_addr_sel),
    .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel),
    .rf_r1_addr_sel(rf_r1_addr_sel), .rf_w_data_sel(rf_w_data_sel),
    .rf_w_addr_sel(rf_w_addr_sel), .ir_ld(ir_ld), .pc_ld(pc_ld),
    .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld_data_sel(pc_ld_data_sel),
    .alu_sel(alu_sel), .cond_ld(cond_ld), .cond_ld_data_sel(cond_ld_data_sel),
    .halted(halted)
`ifdef PUNC_CTRL_PERF_EN
    , .instr_count(instr_count)
`endif
  );

  typedef struct packed {
    logic mwe, mwa, mwd; logic [1:0] mra;
    logic rfw, r0, r1; logic [1:0] wds; logic wa;
    logic irl, pcl, pcc, pci; logic [1:0] pcs; logic [2:0] alu;
    logic cl, cds;
  } ctl_t;
  typedef struct { logic [15:0] ir; logic [2:0] nzp; ctl_t ex; } vec_t;
  typedef struct { ctl_t c; logic h; int id; } exp_t;

  ctl_t obs, cI, cF, cZ, c;
  exp_t q[$];
  exp_t e;
  vec_t tbl[$];
  int total = 0, passed = 0;

  always_comb begin
    obs = '0;
    obs.mwe = mem_w_en; obs.mwa = mem_w_addr_sel; obs.mwd = mem_w_data_sel;
    obs.mra = mem_r_addr_sel; obs.rfw = rf_w_en; obs.r0 = rf_r0_addr_sel;
    obs.r1 = rf_r1_addr_sel; obs.wds = rf_w_data_sel; obs.wa = rf_w_addr_sel;
    obs.irl = ir_ld; obs.pcl = pc_ld; obs.pcc = pc_clr; obs.pci = pc_inc;
    obs.pcs = pc_ld_data_sel; obs.alu = alu_sel; obs.cl = cond_ld;
    obs.cds = cond_ld_data_sel;
  end

  // Scoreboard: one expected control word per clock, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (obs === e.c && halted === e.h) passed++;
      else $display("FAIL ctl[%0d] t=%0t got ctl=%h halted=%b exp ctl=%h halted=%b",
                    e.id, $time, obs, halted, e.c, e.h);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_cyc(input ctl_t cw, input logic h, input int id);
    q.push_back('{c: cw, h: h, id: id});
    step();
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %h exp %h", nm, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    expect_cyc(cI, 1'b0, 900);
    rst = 1'b1;
    expect_cyc(cI, 1'b0, 901);
  endtask

  task automatic run(input logic [15:0] i, input logic [2:0] f, input ctl_t ex, input int id);
    ir = i; {n, z, p} = f;
    expect_cyc(cF, 1'b0, id);
    expect_cyc(cZ, 1'b0, id);
    expect_cyc(ex, 1'b0, id);
  endtask

  task automatic add(input logic [15:0] i, input logic [2:0] f, input ctl_t ex);
    tbl.push_back('{ir: i, nzp: f, ex: ex});
  endtask

  initial begin
    logic [15:0] hw [6];
    rst = 1'b0; ir = 16'h0000; {n, z, p} = 3'b000;
    cZ = '0;
    cI = '0; cI.pcc = 1'b1;
    cF = '0; cF.irl = 1'b1; cF.pci = 1'b1;

    c = '0; c.alu = 3'd1; c.rfw = 1; c.cl = 1;            add(16'h12BF, 3'b010, c); // ADD R1,R2,#-1
    c = '0; c.alu = 3'd0; c.rfw = 1; c.cl = 1;            add(16'h1283, 3'b001, c); // ADD R1,R2,R3
    c = '0; c.alu = 3'd4; c.rfw = 1; c.cl = 1;            add(16'h5262, 3'b100, c); // AND imm
    c = '0; c.alu = 3'd3; c.rfw = 1; c.cl = 1;            add(16'h5283, 3'b010, c); // AND reg
    c = '0; c.alu = 3'd2; c.rfw = 1; c.cl = 1;            add(16'h927F, 3'b001, c); // NOT
    c = '0; c.pcl = 1;                                    add(16'h0404, 3'b010, c); // BRz taken
    c = '0;                                               add(16'h0404, 3'b100, c); // BRz not taken
    c = '0; c.pcl = 1;                                    add(16'h0E00, 3'b001, c); // BRnzp on p
    c = '0;                                               add(16'h0000, 3'b010, c); // BR nzp=000
    c = '0; c.pcl = 1; c.pcs = 2'd1;                      add(16'hC0C0, 3'b000, c); // JMP R3
    c = '0; c.wa = 1; c.wds = 2'd2; c.rfw = 1; c.pcl = 1; c.pcs = 2'd2;
                                                          add(16'h4820, 3'b000, c); // JSR +0x20
    c = '0; c.wa = 1; c.wds = 2'd2; c.rfw = 1; c.pcl = 1; c.pcs = 2'd1;
                                                          add(16'h41C0, 3'b000, c); // JSRR R7
    c = '0; c.mra = 2'd1; c.wds = 2'd1; c.rfw = 1; c.cl = 1; c.cds = 1;
                                                          add(16'h2205, 3'b000, c); // LD
    c = '0; c.mra = 2'd2; c.wds = 2'd1; c.rfw = 1; c.cl = 1; c.cds = 1;
                                                          add(16'h6283, 3'b000, c); // LDR
    c = '0; c.wds = 2'd3; c.rfw = 1; c.cl = 1; c.cds = 1; add(16'hE205, 3'b000, c); // LEA
    c = '0; c.mwe = 1; c.r0 = 1;                          add(16'h3605, 3'b000, c); // ST
    c = '0; c.mwe = 1; c.mwa = 1; c.r0 = 1; c.r1 = 1;     add(16'h7702, 3'b000, c); // STR R3,R4,#2

    step();
    expect_cyc(cI, 1'b0, 800);   // held in reset
`ifdef PUNC_CTRL_PERF_EN
    chk("count_rst", 64'(instr_count), 64'd0);
`endif
    do_reset();

    foreach (tbl[k]) run(tbl[k].ir, tbl[k].nzp, tbl[k].ex, k);
    expect_cyc(cF, 1'b0, 100);   // store strobe lasted one cycle
`ifdef PUNC_CTRL_PERF_EN
    chk("count_table", 64'(instr_count), 64'd17);
`endif

    hw[0] = 16'hF025; hw[1] = 16'hD000; hw[2] = 16'h8000;
    hw[3] = 16'hA000; hw[4] = 16'hB000; hw[5] = 16'hF020;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      c = '0; c.alu = 3'd1; c.rfw = 1; c.cl = 1;
      run(16'h12BF, 3'b000, c, 200 + k);
      ir = hw[k]; {n, z, p} = 3'b111;
      expect_cyc(cF, 1'b0, 300 + k);
      expect_cyc(cZ, 1'b0, 300 + k);
      for (int j = 0; j < ((k < 2) ? 100 : 4); j++) expect_cyc(cZ, 1'b1, 400 + k);
`ifdef PUNC_CTRL_PERF_EN
      chk("count_halt", 64'(instr_count), 64'd1);
`endif
    end

    // Reset lands in the middle of an LD EXECUTE cycle.
    do_reset();
    c = '0; c.mra = 2'd1; c.wds = 2'd1; c.rfw = 1; c.cl = 1; c.cds = 1;
    ir = 16'h2205; {n, z, p} = 3'b000;
    expect_cyc(cF, 1'b0, 500);
    expect_cyc(cZ, 1'b0, 501);
    q.push_back('{c: c, h: 1'b0, id: 502});
    @(negedge clk); #1;
    rst = 1'b0; #1;
    chk("rst_mid_ctl", 64'(obs), 64'(cI));
    chk("rst_mid_halted", 64'(halted), 64'd0);
`ifdef PUNC_CTRL_PERF_EN
    chk("count_mid_rst", 64'(instr_count), 64'd0);
`endif
    step();
    expect_cyc(cI, 1'b0, 503);
    rst = 1'b1;
    expect_cyc(cI, 1'b0, 504);
    c = '0; c.mwe = 1; c.r0 = 1;
    run(16'h3605, 3'b000, c, 505);
    expect_cyc(cF, 1'b0, 506);

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
